// File: rtl/vdc_pkg.sv
// Shared types and constants for the VDC pixel generator.
// Optional pixel doubling is selected with the VDC_PIXDBL_EN macro.
package vdc_pkg;

  typedef logic [3:0] rgbi_t;

  typedef enum logic [1:0] {
    SOLID      = 2'd0,
    OFF        = 2'd1,
    BLINK_SLOW = 2'd2,
    BLINK_FAST = 2'd3
  } cursor_mode_e;

  // Attribute byte layout: colour nibbles and the graphics-mode flag bits.
  localparam int ATR_FG_LSB    = 0;
  localparam int ATR_BG_LSB    = 4;
  localparam int ATR_BLINK     = 4;
  localparam int ATR_UNDERLINE = 5;
  localparam int ATR_REVERSE   = 6;
  localparam int ATR_ALTCHR    = 7;

  localparam int DLY_DEPTH = 16;
  localparam int DLY_W     = 5;

endpackage

// File: rtl/vdc_pixgen_if.sv
// Cell, register and pixel-output signals of the VDC pixel generator.
// No backpressure: pix_valid is a valid-only strobe; rgbi is meaningful when it is 1.
interface vdc_pixgen_if #(
  parameter int CELL_W = 16,
  parameter int ADDR_W = 16
);
  import vdc_pkg::*;

  logic              enable;
  logic              newCol;
  logic              visible;
  logic              blank;
  logic [1:0]        blink;
  logic [4:0]        line;
  logic [CELL_W-1:0] chr;
  logic [7:0]        attr;
  logic [ADDR_W-1:0] cell_addr;

  logic [3:0]        reg_cw;
  logic [3:0]        reg_hss;
  logic              reg_text;
  logic              reg_atr;
  logic              reg_semi;
  logic              reg_rvs;
  logic              reg_cbrate;
  logic              reg_dbl;
  logic [3:0]        reg_fg;
  logic [3:0]        reg_bg;
  logic [4:0]        reg_ul;
  logic [4:0]        reg_cs;
  logic [4:0]        reg_ce;
  logic [1:0]        reg_cm;
  logic [ADDR_W-1:0] reg_cp;

  rgbi_t             rgbi;
  logic              pix_valid;

  modport master (
    output enable, newCol, visible, blank, blink, line, chr, attr, cell_addr,
    output reg_cw, reg_hss, reg_text, reg_atr, reg_semi, reg_rvs, reg_cbrate,
    output reg_dbl, reg_fg, reg_bg, reg_ul, reg_cs, reg_ce, reg_cm, reg_cp,
    input  rgbi, pix_valid
  );

  modport slave (
    input  enable, newCol, visible, blank, blink, line, chr, attr, cell_addr,
    input  reg_cw, reg_hss, reg_text, reg_atr, reg_semi, reg_rvs, reg_cbrate,
    input  reg_dbl, reg_fg, reg_bg, reg_ul, reg_cs, reg_ce, reg_cm, reg_cp,
    output rgbi, pix_valid
  );

endinterface

// File: rtl/vdc_hscroll_dly.sv
// Smooth-scroll delay line: a shift history of pixel samples with a selectable tap.
// Tap 0 passes the current sample straight through.
module vdc_hscroll_dly
  import vdc_pkg::*;
#(
  parameter int DEPTH = DLY_DEPTH,
  parameter int W     = DLY_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [$clog2(DEPTH)-1:0] tap,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enable) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  always_comb begin
    dout = din;
    if (tap != '0) dout = mem[tap - 1'b1];
  end

endmodule

// File: rtl/vdc_pixgen.sv
// VDC pixel generator: latches a character cell, serialises it MSB-first with
// cursor/attribute effects, then smooth-scrolls and registers the colour. Macro: VDC_PIXDBL_EN.
module vdc_pixgen
  import vdc_pkg::*;
#(
  parameter int CELL_W = 16,
  parameter int ADDR_W = 16
) (
  input logic          clk,
  input logic          reset,
  vdc_pixgen_if.slave  bus
);

  localparam int TAP_W = $clog2(DLY_DEPTH);

  // Load-time decode of the incoming cell
  int                cw_i;
  int                lsb_idx;
  logic [3:0]        cw_eff;
  logic [TAP_W-1:0]  hss_eff;
  logic [ADDR_W-1:0] addr_diff;
  logic              cp_hit;
  cursor_mode_e      cm;
  logic              cm_ok;
  logic [2:0]        ca_n;
  logic              crs_n;
  logic              blk_n;
  logic              ulrow_n;
  logic              inv_n;
  logic              last_n;
  logic              fill_n;
  logic [CELL_W-1:0] base_n;
  logic [CELL_W-1:0] pat_n;
  logic [CELL_W-1:0] load_n;

  // Latched cell state
  rgbi_t             fg_q;
  rgbi_t             bg_q;
  logic [2:0]        ca_q;
  logic              crs_q;
  logic              rvs_q;
  logic              semi_q;
  logic              last_q;
  logic              blk_q;
  logic              ulrow_q;
  logic              cell_vld_q;
  logic [CELL_W-1:0] shift_q;

  logic              inv_w;
  logic              fill_w;
  logic              hold_w;
  logic              shift_en;
  rgbi_t             pix_col;
  logic [DLY_W-1:0]  dly_out;
  rgbi_t             rgbi_q;
  logic              pix_valid_q;

  always_comb begin
    cw_i    = int'(bus.reg_cw);
    cw_eff  = (cw_i >= CELL_W) ? 4'(CELL_W - 1) : bus.reg_cw;
    hss_eff = (bus.reg_hss > cw_eff) ? cw_eff : bus.reg_hss;
    lsb_idx = CELL_W - 1 - int'(cw_eff);
  end

  assign addr_diff = bus.cell_addr ^ bus.reg_cp;
  assign cp_hit    = (addr_diff == '0);
  assign cm        = cursor_mode_e'(bus.reg_cm);

  always_comb begin
    cm_ok = (cm == SOLID) ||
            ((cm == BLINK_SLOW) && bus.blink[0]) ||
            ((cm == BLINK_FAST) && bus.blink[1]);
    crs_n = ~bus.reg_text & cp_hit & cm_ok &
            (bus.line >= bus.reg_cs) & (bus.line < bus.reg_ce);
    ca_n  = (~bus.reg_text & bus.reg_atr) ? bus.attr[ATR_REVERSE:ATR_BLINK] : 3'd0;
  end

  // Blink-off beats underline beats the character pattern.
  always_comb begin
    blk_n   = bus.blink[bus.reg_cbrate];
    ulrow_n = (bus.line == bus.reg_ul);
    if (ca_n[0] && blk_n)        base_n = '0;
    else if (ca_n[1] && ulrow_n) base_n = '1;
    else                         base_n = bus.chr;
    inv_n = bus.reg_rvs ^ ca_n[2] ^ crs_n;
    pat_n = base_n ^ {CELL_W{inv_n}};
  end

  // Pixels right of the cell width are pre-filled so shifting alone yields the fill.
  always_comb begin
    last_n = 1'b0;
    for (int i = 0; i < CELL_W; i++) begin
      if (i == lsb_idx) last_n = pat_n[i];
    end
    fill_n = bus.reg_semi ? last_n : inv_n;
    for (int i = 0; i < CELL_W; i++) begin
      load_n[i] = (i >= lsb_idx) ? pat_n[i] : fill_n;
    end
  end

  assign inv_w  = rvs_q ^ ca_q[2] ^ crs_q;
  assign fill_w = semi_q ? last_q : inv_w;
  assign hold_w = ca_q[1] & ulrow_q & ~(ca_q[0] & blk_q);

`ifdef VDC_PIXDBL_EN
  logic phase_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 1'b0;
    end else if (bus.enable) begin
      if (bus.newCol)       phase_q <= 1'b0;
      else if (bus.reg_dbl) phase_q <= ~phase_q;
    end
  end

  assign shift_en = ~bus.reg_dbl | phase_q;
`else
  logic unused_dbl;
  assign unused_dbl = bus.reg_dbl;
  assign shift_en   = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fg_q       <= '0;
      bg_q       <= '0;
      ca_q       <= '0;
      crs_q      <= 1'b0;
      rvs_q      <= 1'b0;
      semi_q     <= 1'b0;
      last_q     <= 1'b0;
      blk_q      <= 1'b0;
      ulrow_q    <= 1'b0;
      cell_vld_q <= 1'b0;
      shift_q    <= '0;
    end else if (bus.enable) begin
      if (bus.newCol) begin
        cell_vld_q <= bus.visible;
        if (bus.visible) begin
          fg_q    <= bus.reg_atr ? bus.attr[ATR_FG_LSB +: 4] : bus.reg_fg;
          bg_q    <= (bus.reg_text & bus.reg_atr) ? bus.attr[ATR_BG_LSB +: 4] : bus.reg_bg;
          ca_q    <= ca_n;
          crs_q   <= crs_n;
          rvs_q   <= bus.reg_rvs;
          semi_q  <= bus.reg_semi;
          last_q  <= last_n;
          blk_q   <= blk_n;
          ulrow_q <= ulrow_n;
          shift_q <= load_n;
        end
      end else if (shift_en && !hold_w) begin
        shift_q <= {shift_q[CELL_W-2:0], fill_w};
      end
    end
  end

  assign pix_col = shift_q[CELL_W-1] ? fg_q : bg_q;

  vdc_hscroll_dly #(
    .DEPTH (DLY_DEPTH),
    .W     (DLY_W)
  ) u_dly (
    .clk    (clk),
    .reset  (reset),
    .enable (bus.enable),
    .tap    (hss_eff),
    .din    ({cell_vld_q, pix_col}),
    .dout   (dly_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rgbi_q      <= '0;
      pix_valid_q <= 1'b0;
    end else if (bus.enable) begin
      if (dly_out[DLY_W-1]) begin
        rgbi_q      <= dly_out[3:0];
        pix_valid_q <= 1'b1;
      end else begin
        rgbi_q      <= bus.blank ? 4'h0 : bus.reg_bg;
        pix_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rgbi      = rgbi_q;
  assign bus.pix_valid = pix_valid_q;

endmodule

// File: tb/tb_vdc_pixgen.sv
// Bench for vdc_pixgen: directed cells plus random cells against a history-based pixel model.
module tb_vdc_pixgen;
  import vdc_pkg::*;

  localparam int CELL_W = 16;
  localparam int ADDR_W = 16;
`ifdef VDC_PIXDBL_EN
  localparam bit DBL_EN = 1'b1;
`else
  localparam bit DBL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vdc_pixgen_if #(.CELL_W(CELL_W), .ADDR_W(ADDR_W)) bus ();

  vdc_pixgen #(.CELL_W(CELL_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a cell is its pixel list, fill, colours; the output is the
  // sampled stream looked up hss enable-cycles back in history.
  typedef struct {
    bit          loaded;
    int          L;
    bit          vld;
    logic [3:0]  fg;
    logic [3:0]  bg;
    logic [15:0] pix;
    int          cw;
    bit          fill;
    bit          hold;
    bit          dbl;
  } cell_t;

  cell_t      cur;
  logic [4:0] s_hist [int];
  int         en_cnt = 0;
  logic [4:0] exp_q [$];
  logic [4:0] seen_q [$];
  logic [4:0] exp_now;
  logic [4:0] m_s, m_o;
  int         m_h, m_cw;

  function automatic cell_t make_cell(input int e);
    cell_t c;
    logic [2:0] ca;
    bit crs, inv, blinked, ul;
    c.loaded = 1'b1;
    c.L      = e;
    c.vld    = bus.visible;
    c.fg     = bus.reg_atr ? bus.attr[3:0] : bus.reg_fg;
    c.bg     = (bus.reg_text && bus.reg_atr) ? bus.attr[7:4] : bus.reg_bg;
    ca       = (!bus.reg_text && bus.reg_atr) ? bus.attr[6:4] : 3'd0;
    c.cw     = (int'(bus.reg_cw) > CELL_W - 1) ? CELL_W - 1 : int'(bus.reg_cw);
    crs      = !bus.reg_text && (bus.cell_addr == bus.reg_cp) &&
               (bus.reg_cm == 2'd0 || (bus.reg_cm[1] && bus.blink[bus.reg_cm[0]])) &&
               (bus.line >= bus.reg_cs) && (bus.line < bus.reg_ce);
    inv      = bus.reg_rvs ^ ca[2] ^ crs;
    blinked  = ca[0] && bus.blink[bus.reg_cbrate];
    ul       = !blinked && ca[1] && (bus.line == bus.reg_ul);
    for (int k = 0; k < CELL_W; k++)
      c.pix[k] = (blinked ? 1'b0 : (ul ? 1'b1 : bus.chr[CELL_W-1-k])) ^ inv;
    c.hold = ul;
    c.fill = bus.reg_semi ? c.pix[c.cw] : inv;
    c.dbl  = DBL_EN && bus.reg_dbl;
    return c;
  endfunction

  function automatic logic [4:0] sample_of(input int e);
    int idx;
    bit p;
    if (!cur.loaded) return 5'd0;
    idx = e - cur.L - 1;
    if (cur.dbl) idx = idx / 2;
    if (cur.hold)         p = cur.pix[0];
    else if (idx <= cur.cw) p = cur.pix[idx];
    else                  p = cur.fill;
    return {cur.vld, p ? cur.fg : cur.bg};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      s_hist.delete();
      cur.loaded = 1'b0;
      exp_now    = 5'd0;
    end else if (bus.enable) begin
      m_s = sample_of(en_cnt);
      s_hist[en_cnt] = m_s;
      m_cw = (int'(bus.reg_cw) > CELL_W - 1) ? CELL_W - 1 : int'(bus.reg_cw);
      m_h  = (int'(bus.reg_hss) > m_cw) ? m_cw : int'(bus.reg_hss);
      m_o  = s_hist.exists(en_cnt - m_h) ? s_hist[en_cnt - m_h] : 5'd0;
      exp_now = m_o[4] ? m_o : {1'b0, (bus.blank ? 4'h0 : bus.reg_bg)};
      if (bus.newCol) begin
        if (bus.visible) cur = make_cell(en_cnt);
        else cur.vld = 1'b0;
      end
      en_cnt++;
    end
    exp_q.push_back(exp_now);
  end

  task automatic tick();
    logic [4:0] e;
    @(negedge clk);
    seen_q.push_back({bus.pix_valid, bus.rgbi});
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty expected queue required one entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check_val("pix", {27'd0, bus.pix_valid, bus.rgbi}, {27'd0, e});
    end
  endtask

  task automatic set_plain(input logic [3:0] cw, input logic [15:0] pat,
                           input logic [3:0] fg, input logic [3:0] bg);
    bus.reg_cw = cw;     bus.chr = pat;       bus.reg_fg = fg;     bus.reg_bg = bg;
    bus.reg_text = 1'b1; bus.reg_atr = 1'b0;  bus.reg_semi = 1'b0; bus.reg_rvs = 1'b0;
    bus.reg_cbrate = 1'b0; bus.reg_dbl = 1'b0; bus.reg_hss = 4'd0; bus.reg_ul = 5'd31;
    bus.reg_cs = 5'd0;   bus.reg_ce = 5'd0;   bus.reg_cm = 2'd1;   bus.reg_cp = '0;
    bus.cell_addr = 16'd1; bus.line = 5'd0;   bus.attr = 8'h00;    bus.blink = 2'b00;
    bus.visible = 1'b1;  bus.blank = 1'b0;
  endtask

  task automatic run_cell(input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      bus.newCol = (i == 0);
      bus.enable = (i == 0) || !gaps || ($urandom_range(7) != 0);
      tick();
    end
    bus.newCol = 1'b0;
    bus.enable = 1'b1;
  endtask

  task automatic rand_cell();
    bus.chr        = 16'($urandom);
    bus.attr       = 8'($urandom);
    bus.reg_cw     = 4'($urandom_range(15));
    bus.reg_hss    = 4'($urandom_range(15));
    bus.reg_text   = 1'($urandom_range(1));
    bus.reg_atr    = 1'($urandom_range(1));
    bus.reg_semi   = 1'($urandom_range(1));
    bus.reg_rvs    = 1'($urandom_range(1));
    bus.reg_cbrate = 1'($urandom_range(1));
    bus.reg_dbl    = 1'($urandom_range(1));
    bus.reg_fg     = 4'($urandom_range(15));
    bus.reg_bg     = 4'($urandom_range(15));
    bus.reg_ul     = 5'($urandom_range(7));
    bus.reg_cs     = 5'($urandom_range(7));
    bus.reg_ce     = 5'($urandom_range(8));
    bus.reg_cm     = 2'($urandom_range(3));
    bus.reg_cp     = 16'($urandom);
    bus.cell_addr  = ($urandom_range(1) != 0) ? bus.reg_cp : 16'($urandom);
    bus.line       = 5'($urandom_range(7));
    bus.blink      = 2'($urandom_range(3));
    bus.visible    = ($urandom_range(9) != 0);
    bus.blank      = 1'($urandom_range(1));
  endtask

  initial begin
    logic [7:0] a5;
    int fg_cnt;
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.newCol = 1'b0;
    set_plain(4'd7, 16'h0000, 4'd0, 4'd0);

    // Reset state
    repeat (3) tick();
    check_val("reset_rgbi", {28'd0, bus.rgbi}, 32'd0);
    check_val("reset_valid", {31'd0, bus.pix_valid}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic serialisation A5 pattern
    set_plain(4'd7, 16'hA500, 4'd1, 4'd0);
    seen_q.delete();
    a5 = 8'hA5;
    run_cell(10, 1'b0);
    for (int k = 0; k < 8; k++)
      check_val("a5_px", {27'd0, seen_q[k+1]}, {27'd0, 1'b1, 3'd0, a5[7-k]});

    // Semigraphic fill of a 12-pixel cell over a 14-cycle interval
    set_plain(4'd11, 16'hFFF0, 4'd9, 4'd0);
    bus.reg_semi = 1'b1;
    seen_q.delete();
    run_cell(14, 1'b0);
    set_plain(4'd7, 16'h0000, 4'd9, 4'd0);
    run_cell(4, 1'b0);
    for (int k = 1; k <= 14; k++)
      check_val("semi_fill", {27'd0, seen_q[k]}, {27'd0, 5'h19});

    // Pixel doubling
    set_plain(4'd7, 16'h8000, 4'd3, 4'd0);
    bus.reg_dbl = 1'b1;
    seen_q.delete();
    run_cell(17, 1'b0);
    fg_cnt = 0;
    for (int k = 1; k <= 16; k++) if (seen_q[k] == 5'h13) fg_cnt++;
    check_val("dbl_fg_count", fg_cnt, DBL_EN ? 32'd2 : 32'd1);
    check_val("dbl_first_fg", {27'd0, seen_q[1]}, 32'h13);

    // Smooth scroll at 3 and 0 under the model
    set_plain(4'd15, 16'hC3A5, 4'd6, 4'd1);
    bus.reg_hss = 4'd3;
    run_cell(20, 1'b0);
    bus.reg_hss = 4'd0;
    run_cell(20, 1'b0);

    // Solid cursor turns blank chr into fg; cursor off leaves bg
    set_plain(4'd7, 16'h0000, 4'd5, 4'd2);
    bus.reg_text = 1'b0; bus.reg_cm = 2'd0; bus.reg_cp = 16'h1234; bus.cell_addr = 16'h1234;
    bus.line = 5'd3; bus.reg_cs = 5'd2; bus.reg_ce = 5'd6;
    seen_q.delete();
    run_cell(10, 1'b0);
    for (int k = 1; k <= 8; k++) check_val("crs_on", {27'd0, seen_q[k]}, 32'h15);
    bus.reg_cm = 2'd1;
    seen_q.delete();
    run_cell(10, 1'b0);
    for (int k = 1; k <= 8; k++) check_val("crs_off", {27'd0, seen_q[k]}, 32'h12);

    // Reset mid-cell, with newCol asserted, wins; no stale pixels afterwards
    set_plain(4'd15, 16'hFFFF, 4'd7, 4'd0);
    run_cell(5, 1'b0);
    reset = 1'b1;
    bus.newCol = 1'b1;
    tick();
    check_val("rst_mid_rgbi", {28'd0, bus.rgbi}, 32'd0);
    check_val("rst_mid_valid", {31'd0, bus.pix_valid}, 32'd0);
    reset = 1'b0;
    bus.newCol = 1'b0;
    bus.blank = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val("post_rst_valid", {31'd0, bus.pix_valid}, 32'd0);
    end

    // Randomised cells with enable gaps
    for (int n = 0; n < 300; n++) begin
      rand_cell();
      run_cell($urandom_range(1, 24), 1'b1);
    end
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
